// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two bursting requesters sharing a 2:1 mux channel.
// Grant is held for a whole burst; the muxed beat is captured in one output register.
module mux_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             select,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               last_q, last_d;

  logic               take;
  logic               rdy0, rdy1;
  logic               acc0, acc1, acc;
  logic [WIDTH-1:0]   acc_data;
  logic               acc_last;

  // The output register can accept a beat when empty or draining this cycle.
  assign take = !ov_q || out_ready;
  assign rdy0 = (state_q == GRANT0) && take;
  assign rdy1 = (state_q == GRANT1) && take;
  assign acc0 = in0_valid && rdy0;
  assign acc1 = in1_valid && rdy1;
  assign acc  = acc0 || acc1;

  assign acc_data = acc1 ? in1_data : in0_data;
  assign acc_last = acc1 ? in1_last : in0_last;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in0_valid && (!in1_valid || !prio_q)) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end else if (in1_valid) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT0: begin
        if (acc0 && in0_last) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      GRANT1: begin
        if (acc1 && in1_last) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // acc is never set in IDLE, so this cannot collide with the grant-time clear.
    if (acc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    ov_d   = ov_q;
    data_d = data_q;
    last_d = last_q;
    if (acc) begin
      ov_d   = 1'b1;
      data_d = acc_data;
      last_d = acc_last;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign in0_ready = rdy0;
  assign in1_ready = rdy1;
  assign out_valid = ov_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign select    = sel_q;
  assign busy      = (state_q != IDLE);
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a default instance plus a CNT_W=2 instance
// driven by the same inputs; each has its own expected-beat queue.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in0_valid = 1'b0, in0_last = 1'b0, in1_valid = 1'b0, in1_last = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       out_ready = 1'b1;

  logic       in0_ready, in1_ready, out_valid, out_last, select, busy;
  logic [7:0] out_data, beat_cnt;
  logic       s_in0_ready, s_in1_ready, s_out_valid, s_out_last, s_select, s_busy;
  logic [7:0] s_out_data;
  logic [1:0] s_beat_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_s[$];
  bit         bp_done, stall_done;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .select(select), .busy(busy), .beat_cnt(beat_cnt)
  );

  mux_rr_arbiter #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_ready(out_ready),
    .select(s_select), .busy(s_busy), .beat_cnt(s_beat_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
    exp_s.push_back({l, d});
  endtask

  task automatic run_monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_main: unexpected beat got %h/%b, required none", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_bad++;
            $display("FAIL sb_main: got data=%h last=%b, required data=%h last=%b",
                     out_data, out_last, e[7:0], e[8]);
          end
        end
      end
      if (!reset && s_out_valid && out_ready) begin
        n_cmp++;
        if (exp_s.size() == 0) begin
          n_bad++;
          $display("FAIL sb_sat: unexpected beat got %h/%b, required none", s_out_data, s_out_last);
        end else begin
          e = exp_s.pop_front();
          if ({s_out_last, s_out_data} !== e) begin
            n_bad++;
            $display("FAIL sb_sat: got data=%h last=%b, required data=%h last=%b",
                     s_out_data, s_out_last, e[7:0], e[8]);
          end
        end
      end
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [7:0] d, input logic l);
    if (port == 0) begin
      in0_valid = v; in0_data = d; in0_last = l;
    end else begin
      in1_valid = v; in1_data = d; in1_last = l;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
    bp_done = 1'b0;
    stall_done = 1'b0;
    exp_q.delete();
    exp_s.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Starts and returns just after a rising edge; the last beat stays driven on return.
  task automatic send_burst(input int port, input logic [7:0] base, input int n, input bit end_last);
    logic [7:0] d;
    logic       rdy, other;
    bit         ok;
    int         guard;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      drive(port, 1'b1, d, end_last && (i == n - 1));
      ok = 1'b0;
      guard = 0;
      while (!ok) begin
        @(negedge clk);
        rdy   = (port == 0) ? in0_ready : in1_ready;
        other = (port == 0) ? in1_ready : in0_ready;
        if (out_valid && !out_ready) begin
          n_cmp++;
          if (rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_stall: port %0d ready=%b while output stalled, required 0", port, rdy);
          end
        end
        if (rdy === 1'b1) begin
          ok = 1'b1;
          n_cmp++;
          if (select !== port[0] || busy !== 1'b1 || other !== 1'b0) begin
            n_bad++;
            $display("FAIL grant: port %0d beat %h select=%b busy=%b other_ready=%b, required %b/1/0",
                     port, d, select, busy, other, port[0]);
          end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
          guard++;
          if (guard > 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: port %0d beat %h never accepted, required acceptance", port, d);
            break;
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || exp_s.size() != 0) && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_s.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d beats still expected, required 0/0", exp_q.size(), exp_s.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, out_last, select, busy, beat_cnt, in0_ready, in1_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: ov=%b od=%h ol=%b sel=%b busy=%b cnt=%h r0=%b r1=%b, required all 0",
               out_valid, out_data, out_last, select, busy, beat_cnt, in0_ready, in1_ready);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    push_exp(8'hA1, 1'b1);
    drive(0, 1'b1, 8'hA1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (in0_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_c0: in0_ready=%b busy=%b, required 0/0", in0_ready, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (in0_ready !== 1'b1 || busy !== 1'b1 || select !== 1'b0) begin
      n_bad++;
      $display("FAIL single_c1: in0_ready=%b busy=%b select=%b, required 1/1/0", in0_ready, busy, select);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_last !== 1'b1 || beat_cnt !== 8'd1 ||
        busy !== 1'b0 || select !== 1'b0) begin
      n_bad++;
      $display("FAIL single_c2: ov=%b od=%h ol=%b cnt=%0d busy=%b sel=%b, required 1/a1/1/1/0/0",
               out_valid, out_data, out_last, beat_cnt, busy, select);
    end
    wait_drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_exp(8'h10, 1'b0); push_exp(8'h11, 1'b1);
      push_exp(8'h20, 1'b0); push_exp(8'h21, 1'b1);
    end
    fork
      begin
        send_burst(0, 8'h10, 2, 1'b1);
        send_burst(0, 8'h10, 2, 1'b1);
        in0_valid = 1'b0;
      end
      begin
        send_burst(1, 8'h20, 2, 1'b1);
        send_burst(1, 8'h20, 2, 1'b1);
        in1_valid = 1'b0;
      end
      begin
        int   g[$];
        logic sels[$];
        logic pb;
        pb = 1'b0;
        for (int cyc = 0; cyc < 80 && g.size() < 4; cyc++) begin
          @(negedge clk);
          if (busy && !pb) begin
            g.push_back(cyc);
            sels.push_back(select);
          end
          pb = busy;
        end
        n_cmp++;
        if (g.size() != 4) begin
          n_bad++;
          $display("FAIL rr_grants: saw %0d grants, required 4", g.size());
        end else begin
          for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sels[k] !== (k % 2 == 1)) begin
              n_bad++;
              $display("FAIL rr_select: grant %0d select=%b, required %0d", k, sels[k], k % 2);
            end
            if (k > 0) begin
              n_cmp++;
              if (g[k] - g[k-1] != 3) begin
                n_bad++;
                $display("FAIL rr_bubble: grant gap %0d cycles, required 3", g[k] - g[k-1]);
              end
            end
          end
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) push_exp(8'h30 + 8'(k), k == 3);
    fork
      begin
        send_burst(1, 8'h30, 4, 1'b1);
        in1_valid = 1'b0;
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          k++;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        logic       ps;
        logic [7:0] pd;
        ps = 1'b0;
        pd = '0;
        while (!bp_done) begin
          @(negedge clk);
          if (ps) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== pd) begin
              n_bad++;
              $display("FAIL bp_hold: ov=%b data=%h, required 1/%h", out_valid, out_data, pd);
            end
          end
          ps = out_valid && !out_ready;
          pd = out_data;
        end
      end
    join
    @(negedge clk);
    n_cmp++;
    if (beat_cnt !== 8'd4 || select !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_count: beat_cnt=%0d select=%b, required 4/1", beat_cnt, select);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    do_reset();
    push_exp(8'h40, 1'b0); push_exp(8'h41, 1'b1); push_exp(8'h50, 1'b1);
    fork
      begin
        send_burst(0, 8'h40, 1, 1'b0);
        in0_valid = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (busy !== 1'b1 || select !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_lock: busy=%b select=%b, required 1/0", busy, select);
          end
          @(posedge clk); #1;
        end
        send_burst(0, 8'h41, 1, 1'b1);
        in0_valid = 1'b0;
        stall_done = 1'b1;
      end
      begin
        send_burst(1, 8'h50, 1, 1'b1);
        in1_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (!stall_done && g < 200) begin
          @(negedge clk);
          g++;
          n_cmp++;
          if (in1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_preempt: in1_ready=%b during in0 burst, required 0", in1_ready);
          end
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    push_exp(8'h55, 1'b1);
    send_burst(0, 8'h55, 1, 1'b1);
    in0_valid = 1'b0;
    wait_drain();
    @(posedge clk); #1;
    push_exp(8'h60, 1'b0); push_exp(8'h61, 1'b0);
    send_burst(1, 8'h60, 2, 1'b0);
    in1_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_s.delete();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || select !== 1'b0 || busy !== 1'b0 ||
        beat_cnt !== 8'd0 || s_beat_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: ov=%b od=%h sel=%b busy=%b cnt=%0d scnt=%0d, required all 0",
               out_valid, out_data, select, busy, beat_cnt, s_beat_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    push_exp(8'h70, 1'b1); push_exp(8'h71, 1'b1);
    fork
      begin
        send_burst(0, 8'h70, 1, 1'b1);
        in0_valid = 1'b0;
      end
      begin
        send_burst(1, 8'h71, 1, 1'b1);
        in1_valid = 1'b0;
      end
    join
    wait_drain();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 6; k++) push_exp(8'h80 + 8'(k), k == 5);
    send_burst(0, 8'h80, 6, 1'b1);
    in0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_beat_cnt !== 2'd3 || beat_cnt !== 8'd6) begin
      n_bad++;
      $display("FAIL saturation: sat beat_cnt=%0d wide beat_cnt=%0d, required 3/6", s_beat_cnt, beat_cnt);
    end
    wait_drain();
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_beat();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
